// File: rtl/switch_ctrl_pkg.sv
// Shared definitions for the switch input controller.
// Contents:
//   ADDR_*       Avalon word addresses of the four slave registers
//   edge_mode_e  edge capture type selector
//   cnt_width()  bit width needed for a counter that runs 0..n-1
package switch_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_RAW  = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_mode_e;

  // A counter that only ever holds 0..n-1 needs at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch input: two-flop synchroniser followed by a tick-sampled debouncer.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   raw_i        raw switch input, asynchronous to clk_i
//   tick_i       one-cycle debounce sample strobe
//   sync_o       synchronised raw value
//   debounced_o  accepted (debounced) level
module switch_debounce_bit
  import switch_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  input  logic tick_i,
  output logic sync_o,
  output logic debounced_o
);

  localparam int unsigned CntW = cnt_width(STABLE_SAMPLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_SAMPLES - 1);

  logic            sync_meta_q, sync_meta_d;
  logic            sync_q, sync_d;
  logic            deb_q, deb_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      deb_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      deb_q       <= deb_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    sync_meta_d = raw_i;
    sync_d      = sync_meta_q;
    deb_d       = deb_q;
    cnt_d       = cnt_q;
    if (tick_i) begin
      // Any sample that agrees with the current level discards the pending change.
      if (sync_q == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        deb_d = sync_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sync_o      = sync_q;
  assign debounced_o = deb_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Avalon-MM slave that conditions board switches/keys: synchronise, debounce,
// capture edges and raise a maskable level interrupt.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   in_port            raw switch inputs (asynchronous)
//   address            word address: 0 level, 1 irq mask, 2 raw sync, 3 edge (W1C)
//   chipselect, write  write strobe qualifiers
//   writedata          write data
//   readdata           registered read data, 1-cycle latency, zero-extended
//   irq                registered level interrupt, |(edge & mask)
module switch_input_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH          = 18,
  parameter int unsigned TICK_DIV       = 500000,
  parameter int unsigned STABLE_SAMPLES = 3,
  parameter int unsigned EDGE_MODE      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned PreW = cnt_width(TICK_DIV);
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);
  localparam edge_mode_e EdgeMode = edge_mode_e'(2'(EDGE_MODE));

  logic [PreW-1:0]  presc_q, presc_d;
  logic             tick;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] edge_w1c;
  logic             wr_en;
  logic             unused_wdata;

  // Upper writedata bits have no home when WIDTH < 32.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk_i      (clk),
      .rst_i      (reset),
      .raw_i      (in_port[i]),
      .tick_i     (tick),
      .sync_o     (sync[i]),
      .debounced_o(debounced[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      deb_prev_q <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      deb_prev_q <= deb_prev_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign tick = (presc_q == PreMax);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;

    deb_prev_d = debounced;
    case (EdgeMode)
      EDGE_FALL: edge_evt = ~debounced & deb_prev_q;
      EDGE_ANY:  edge_evt = debounced ^ deb_prev_q;
      default:   edge_evt = debounced & ~deb_prev_q;
    endcase

    wr_en    = chipselect & write;
    mask_d   = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    edge_w1c = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    // A new event outranks a same-cycle clear so no edge is ever lost.
    edge_d   = (edge_q & ~edge_w1c) | edge_evt;

    case (address)
      ADDR_DATA: readdata_d = 32'(debounced);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_RAW:  readdata_d = 32'(sync);
      default:   readdata_d = 32'(edge_q);
    endcase

    irq_d = |(edge_q & mask_q);
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with TICK_DIV=4, STABLE_SAMPLES=3,
// rising-edge capture, WIDTH=18. Stimulus changes and sampling both happen on
// the falling clock edge; now_n counts falling edges since reset release.
module tb_switch_input_ctrl;
  import switch_ctrl_pkg::*;

  localparam int unsigned W = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_port = '0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned now_n = 0;

  always #5 clk = ~clk;

  switch_input_ctrl #(
    .WIDTH         (W),
    .TICK_DIV      (4),
    .STABLE_SAMPLES(3),
    .EDGE_MODE     (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic step();
    @(negedge clk);
    now_n++;
  endtask

  task automatic goto_n(input int unsigned n);
    while (now_n < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_port = '0;
    chipselect = 1'b0;
    write = 1'b0;
    address = ADDR_DATA;
    writedata = '0;
    step();
    step();
    reset = 1'b0;
    now_n = 0;
  endtask

  // Write lands on the next rising edge; address is left in place.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write = 1'b1;
    step();
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_port = '1;
    bus_write(ADDR_MASK, 32'h3FFFF);
    goto_n(16);
    checks++;
    if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq);
    else passed++;
    checks++;
    if (readdata !== 32'h3FFFF) $display("FAIL pre_reset_mask: got %h want 0003ffff", readdata);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (readdata !== 32'h0) $display("FAIL reset_async_rd: got %h want 00000000", readdata);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_async_irq: got %b want 0", irq);
    else passed++;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      step();
      checks++;
      if (readdata !== 32'h0) $display("FAIL reset_read_%0d: got %h want 00000000", a, readdata);
      else passed++;
    end
    reset = 1'b0;
    now_n = 0;
    address = ADDR_DATA;
    while (now_n < 20 && readdata !== 32'h3FFFF) step();
    checks++;
    if (now_n !== 13) $display("FAIL reset_release_latency: got %0d cycles want 13", now_n);
    else passed++;
  endtask

  task automatic test_clean_press();
    do_reset();
    bus_write(ADDR_MASK, 32'h1);
    address = ADDR_DATA;
    in_port[0] = 1'b1;
    goto_n(12);
    checks++;
    if (readdata !== 32'h0) $display("FAIL press_not_early: got %h want 00000000", readdata);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL press_irq_idle: got %b want 0", irq);
    else passed++;
    step();
    checks++;
    if (readdata !== 32'h1) $display("FAIL press_accept: got %h want 00000001", readdata);
    else passed++;
    checks++;
    if (irq !== 1'b0) $display("FAIL press_irq_not_yet: got %b want 0", irq);
    else passed++;
    address = ADDR_EDGE;
    step();
    checks++;
    if (irq !== 1'b1) $display("FAIL press_irq_2cyc: got %b want 1", irq);
    else passed++;
    checks++;
    if (readdata !== 32'h1) $display("FAIL press_edge: got %h want 00000001", readdata);
    else passed++;
  endtask

  task automatic test_bounce();
    logic early;
    early = 1'b0;
    do_reset();
    in_port[5] = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (readdata !== 32'h0) early = 1'b1;
      if (now_n == 8) in_port[5] = 1'b0;
      if (now_n == 12) in_port[5] = 1'b1;
    end
    checks++;
    if (early !== 1'b0) $display("FAIL bounce_no_early: got %b want 0", early);
    else passed++;
    step();
    checks++;
    if (readdata !== 32'h20) $display("FAIL bounce_accept: got %h want 00000020", readdata);
    else passed++;
    address = ADDR_EDGE;
    step();
    checks++;
    if (readdata !== 32'h20) $display("FAIL bounce_one_edge: got %h want 00000020", readdata);
    else passed++;
    address = ADDR_DATA;
    repeat (8) step();
    checks++;
    if (readdata !== 32'h20) $display("FAIL bounce_stable: got %h want 00000020", readdata);
    else passed++;
  endtask

  task automatic test_w1c_priority();
    do_reset();
    in_port[1:0] = 2'b11;
    goto_n(13);
    bus_write(ADDR_EDGE, 32'h1);
    step();
    checks++;
    if (readdata !== 32'h2) $display("FAIL w1c_clear_bit0: got %h want 00000002", readdata);
    else passed++;
    goto_n(16);
    in_port[1] = 1'b0;
    goto_n(28);
    in_port[1] = 1'b1;
    step();
    bus_write(ADDR_EDGE, 32'h2);
    step();
    checks++;
    if (readdata !== 32'h0) $display("FAIL w1c_clear_bit1: got %h want 00000000", readdata);
    else passed++;
    goto_n(40);
    checks++;
    if (readdata !== 32'h0) $display("FAIL w1c_no_early_set: got %h want 00000000", readdata);
    else passed++;
    bus_write(ADDR_EDGE, 32'h2);
    step();
    checks++;
    if (readdata !== 32'h2) $display("FAIL w1c_set_wins: got %h want 00000002", readdata);
    else passed++;
  endtask

  task automatic test_mask_gating();
    do_reset();
    in_port[4] = 1'b1;
    goto_n(15);
    checks++;
    if (irq !== 1'b0) $display("FAIL mask_gate_off: got %b want 0", irq);
    else passed++;
    bus_write(ADDR_MASK, 32'h10);
    checks++;
    if (irq !== 1'b0) $display("FAIL mask_irq_not_yet: got %b want 0", irq);
    else passed++;
    step();
    checks++;
    if (irq !== 1'b1) $display("FAIL mask_irq_on: got %b want 1", irq);
    else passed++;
    bus_write(ADDR_EDGE, 32'h10);
    checks++;
    if (irq !== 1'b1) $display("FAIL clear_irq_lag: got %b want 1", irq);
    else passed++;
    step();
    checks++;
    if (irq !== 1'b0) $display("FAIL clear_irq_off: got %b want 0", irq);
    else passed++;
  endtask

  task automatic test_read_latency();
    do_reset();
    in_port = 18'h20001;
    goto_n(13);
    in_port = 18'h00003;
    goto_n(16);
    bus_write(ADDR_MASK, 32'h0F0F0);
    goto_n(18);
    address = ADDR_DATA;
    step();
    checks++;
    if (readdata !== 32'h20001) $display("FAIL rd_lat_data: got %h want 00020001", readdata);
    else passed++;
    address = ADDR_RAW;
    step();
    checks++;
    if (readdata !== 32'h00003) $display("FAIL rd_lat_raw: got %h want 00000003", readdata);
    else passed++;
    address = ADDR_EDGE;
    step();
    checks++;
    if (readdata !== 32'h20001) $display("FAIL rd_lat_edge: got %h want 00020001", readdata);
    else passed++;
    address = ADDR_MASK;
    step();
    checks++;
    if (readdata !== 32'h0F0F0) $display("FAIL rd_lat_mask: got %h want 0000f0f0", readdata);
    else passed++;
    goto_n(26);
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    bus_write(ADDR_RAW, 32'hFFFF_FFFF);
    bus_write(ADDR_MASK, 32'hFFFF_FFFF);
    address = ADDR_DATA;
    step();
    checks++;
    if (readdata !== 32'h00003) $display("FAIL ro_data_write_ignored: got %h want 00000003", readdata);
    else passed++;
    address = ADDR_MASK;
    step();
    checks++;
    if (readdata !== 32'h3FFFF) $display("FAIL mask_upper_zero: got %h want 0003ffff", readdata);
    else passed++;
    address = ADDR_RAW;
    step();
    checks++;
    if (readdata !== 32'h00003) $display("FAIL ro_raw_write_ignored: got %h want 00000003", readdata);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c_priority();
    test_mask_gating();
    test_read_latency();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
